// File: rtl/lfsr_to_code_phase_if.sv
// Request/result bundle for the C/A-code LFSR-to-phase decoder.
// The master drives the snapshot and start pulse; the slave (decoder) returns status and phase.
interface lfsr_to_code_phase_if;
  logic       start;
  logic [9:0] g1_in;
  logic [9:0] g2_in;
  logic       busy;
  logic       done;
  logic [9:0] phase;
  logic       phase_valid;
  logic       not_found;
  logic       g2_mismatch;

  modport master (
    output start, g1_in, g2_in,
    input  busy, done, phase, phase_valid, not_found, g2_mismatch
  );

  modport slave (
    input  start, g1_in, g2_in,
    output busy, done, phase, phase_valid, not_found, g2_mismatch
  );
endinterface

// File: rtl/lfsr_to_code_phase.sv
// Recovers the 10-bit C/A code phase from a G1/G2 snapshot by stepping local replicas
// from the epoch state one chip per clock until G1 matches, then confirming G2.
module lfsr_to_code_phase #(
  parameter logic [9:0] G1_INIT  = 10'h3FF,
  parameter logic [9:0] G2_INIT  = 10'h3FF,
  parameter int         CODE_LEN = 1023
) (
  input logic                  clk,
  input logic                  rst,
  lfsr_to_code_phase_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, SEARCH, DONE} state_t;

  localparam logic [9:0] LAST_CNT = 10'(CODE_LEN - 1);

  state_t     state, state_nxt;
  logic [9:0] g1, g1_nxt;
  logic [9:0] g2, g2_nxt;
  logic [9:0] tgt_g1, tgt_g1_nxt;
  logic [9:0] tgt_g2, tgt_g2_nxt;
  logic [9:0] cnt, cnt_nxt;
  logic [9:0] phase, phase_nxt;
  logic       busy, busy_nxt;
  logic       done, done_nxt;
  logic       phase_valid, phase_valid_nxt;
  logic       not_found, not_found_nxt;
  logic       g2_mismatch, g2_mismatch_nxt;

  function automatic logic [9:0] g1_step(input logic [9:0] s);
    return {s[8:0], s[2] ^ s[9]};
  endfunction

  function automatic logic [9:0] g2_step(input logic [9:0] s);
    return {s[8:0], s[1] ^ s[2] ^ s[5] ^ s[7] ^ s[8] ^ s[9]};
  endfunction

  // Status outputs are registered so they appear together with the done pulse.
  always_comb begin
    state_nxt       = state;
    g1_nxt          = g1;
    g2_nxt          = g2;
    tgt_g1_nxt      = tgt_g1;
    tgt_g2_nxt      = tgt_g2;
    cnt_nxt         = cnt;
    phase_nxt       = phase;
    busy_nxt        = busy;
    done_nxt        = 1'b0;
    phase_valid_nxt = phase_valid;
    not_found_nxt   = not_found;
    g2_mismatch_nxt = g2_mismatch;

    case (state)
      IDLE: begin
        if (bus.start) begin
          tgt_g1_nxt      = bus.g1_in;
          tgt_g2_nxt      = bus.g2_in;
          g1_nxt          = G1_INIT;
          g2_nxt          = G2_INIT;
          cnt_nxt         = '0;
          phase_valid_nxt = 1'b0;
          not_found_nxt   = 1'b0;
          g2_mismatch_nxt = 1'b0;
          busy_nxt        = 1'b1;
          state_nxt       = SEARCH;
        end
      end

      SEARCH: begin
        if (g1 == tgt_g1) begin
          phase_nxt       = cnt;
          phase_valid_nxt = (g2 == tgt_g2);
          g2_mismatch_nxt = (g2 != tgt_g2);
          busy_nxt        = 1'b0;
          done_nxt        = 1'b1;
          state_nxt       = DONE;
        end else if (cnt == LAST_CNT) begin
          // Every reachable G1 state has been visited; the snapshot is not a code state.
          not_found_nxt = 1'b1;
          phase_nxt     = '0;
          busy_nxt      = 1'b0;
          done_nxt      = 1'b1;
          state_nxt     = DONE;
        end else begin
          g1_nxt  = g1_step(g1);
          g2_nxt  = g2_step(g2);
          cnt_nxt = cnt + 10'd1;
        end
      end

      DONE: begin
        state_nxt = IDLE;
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      g1          <= '0;
      g2          <= '0;
      tgt_g1      <= '0;
      tgt_g2      <= '0;
      cnt         <= '0;
      phase       <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      phase_valid <= 1'b0;
      not_found   <= 1'b0;
      g2_mismatch <= 1'b0;
    end else begin
      state       <= state_nxt;
      g1          <= g1_nxt;
      g2          <= g2_nxt;
      tgt_g1      <= tgt_g1_nxt;
      tgt_g2      <= tgt_g2_nxt;
      cnt         <= cnt_nxt;
      phase       <= phase_nxt;
      busy        <= busy_nxt;
      done        <= done_nxt;
      phase_valid <= phase_valid_nxt;
      not_found   <= not_found_nxt;
      g2_mismatch <= g2_mismatch_nxt;
    end
  end

  assign bus.busy        = busy;
  assign bus.done        = done;
  assign bus.phase       = phase;
  assign bus.phase_valid = phase_valid;
  assign bus.not_found   = not_found;
  assign bus.g2_mismatch = g2_mismatch;

endmodule

// File: tb/tb_lfsr_to_code_phase.sv
// Randomized bench for lfsr_to_code_phase: a table of epoch-relative G1/G2 states is the
// reference, and each search result is predicted by looking the snapshot up in that table.
module tb_lfsr_to_code_phase;

  logic clk;
  logic rst;
  int   vectors;
  int   miscompares;

  lfsr_to_code_phase_if bus ();

  lfsr_to_code_phase dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [9:0] g1_seq [1023];
  logic [9:0] g2_seq [1023];

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Starts a search and returns the clock cycle (cycle 1 begins at the sampling edge) in which
  // done is seen; -1 if it never arrives. Optionally re-pulses start mid-search.
  task automatic applyStimulus(input logic [9:0] a, input logic [9:0] b,
                               input int glitch_at, output int lat);
    @(negedge clk);
    bus.start = 1'b1;
    bus.g1_in = a;
    bus.g2_in = b;
    @(negedge clk);
    bus.start = 1'b0;
    bus.g1_in = 10'($urandom);
    bus.g2_in = 10'($urandom);
    lat = 1;
    while (!bus.done && lat < 1100) begin
      if (lat == glitch_at) begin
        bus.start = 1'b1;
        bus.g1_in = g1_seq[10];
        bus.g2_in = g2_seq[10];
      end else begin
        bus.start = 1'b0;
      end
      @(negedge clk);
      lat++;
    end
    bus.start = 1'b0;
    if (!bus.done) lat = -1;
  endtask

  task automatic runCase(input string name, input logic [9:0] a, input logic [9:0] b,
                         input int glitch_at, input bit poke_done);
    int         lat;
    int         exp_lat;
    logic [9:0] exp_phase;
    bit         found;
    found     = 1'b0;
    exp_phase = '0;
    for (int p = 0; p < 1023; p++) begin
      if (!found && g1_seq[p] == a) begin
        found     = 1'b1;
        exp_phase = 10'(p);
      end
    end
    exp_lat = found ? int'(exp_phase) + 2 : 1024;

    applyStimulus(a, b, glitch_at, lat);
    checkOutput({name, ".latency"}, lat, exp_lat);
    checkOutput({name, ".phase"}, bus.phase, exp_phase);
    checkOutput({name, ".phase_valid"}, bus.phase_valid, found && (g2_seq[exp_phase] == b));
    checkOutput({name, ".not_found"}, bus.not_found, !found);
    checkOutput({name, ".g2_mismatch"}, bus.g2_mismatch, found && (g2_seq[exp_phase] != b));
    checkOutput({name, ".busy_at_done"}, bus.busy, 1'b0);

    if (poke_done) bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    checkOutput({name, ".done_one_cycle"}, bus.done, 1'b0);
    checkOutput({name, ".phase_held"}, bus.phase, exp_phase);
    if (poke_done) begin
      @(negedge clk);
      checkOutput({name, ".start_in_done_ignored"}, bus.busy, 1'b0);
    end
  endtask

  initial begin
    logic [9:0] s1;
    logic [9:0] s2;
    int         p;
    int         wait_cycles;
    vectors     = 0;
    miscompares = 0;

    s1 = 10'h3FF;
    s2 = 10'h3FF;
    for (int i = 0; i < 1023; i++) begin
      g1_seq[i] = s1;
      g2_seq[i] = s2;
      s1 = {s1[8:0], s1[2] ^ s1[9]};
      s2 = {s2[8:0], s2[1] ^ s2[2] ^ s2[5] ^ s2[7] ^ s2[8] ^ s2[9]};
    end

    bus.start = 1'b0;
    bus.g1_in = '0;
    bus.g2_in = '0;
    rst       = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset.busy", bus.busy, 1'b0);
    checkOutput("reset.done", bus.done, 1'b0);
    checkOutput("reset.phase", bus.phase, 10'd0);
    checkOutput("reset.phase_valid", bus.phase_valid, 1'b0);
    checkOutput("reset.not_found", bus.not_found, 1'b0);
    checkOutput("reset.g2_mismatch", bus.g2_mismatch, 1'b0);
    rst = 1'b1;

    runCase("phase0", g1_seq[0], g2_seq[0], 0, 1'b0);
    runCase("phase1", 10'h3FE, g2_seq[1], 0, 1'b0);
    runCase("phase2", g1_seq[2], g2_seq[2], 0, 1'b1);
    runCase("phase1021", g1_seq[1021], g2_seq[1021], 0, 1'b0);
    runCase("phase1022", g1_seq[1022], g2_seq[1022], 0, 1'b0);
    runCase("g1_zero", 10'h000, 10'h3FF, 0, 1'b0);
    runCase("g2_off_by_one", g1_seq[5], g2_seq[6], 0, 1'b0);

    for (int i = 0; i < 16; i++) begin
      p = $urandom_range(0, 1022);
      if (i % 3 == 2)
        runCase("rand_g2", g1_seq[p], 10'($urandom), 0, 1'b0);
      else
        runCase("rand_phase", g1_seq[p], g2_seq[p], 0, 1'b0);
    end
    runCase("rand_g1", 10'($urandom), 10'($urandom), 0, 1'b0);

    runCase("restart_ignored", g1_seq[300], g2_seq[300], 50, 1'b0);

    // Abort a search with reset: outputs drop at once and no done follows.
    @(negedge clk);
    bus.start = 1'b1;
    bus.g1_in = g1_seq[600];
    bus.g2_in = g2_seq[600];
    @(negedge clk);
    bus.start = 1'b0;
    wait_cycles = 0;
    while (wait_cycles < 100) begin
      @(negedge clk);
      wait_cycles++;
    end
    checkOutput("abort.busy_before", bus.busy, 1'b1);
    #2 rst = 1'b0;
    #1;
    checkOutput("abort.busy", bus.busy, 1'b0);
    checkOutput("abort.phase", bus.phase, 10'd0);
    checkOutput("abort.phase_valid", bus.phase_valid, 1'b0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checkOutput("abort.no_done", bus.done, 1'b0);
    end
    rst = 1'b1;
    runCase("after_abort", g1_seq[77], g2_seq[77], 0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
